// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and
// line-timing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // 100 MHz system clock, 9600 baud.
  localparam int DEFAULT_BAUD_DIV = 10417;

  // 8N1: start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser. rd_data shows the head
// entry straight from the storage array, so a pop edge consumes it directly.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_DEPTH_BIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [FIFO_DEPTH_BIT:0] count
);

  logic [7:0]                mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_BIT-1:0] wr_ptr;
  logic [FIFO_DEPTH_BIT-1:0] rd_ptr;
  logic [FIFO_DEPTH_BIT:0]   cnt_q;
  logic                      push;
  logic                      pop;

  // A write while full is dropped even when a pop frees a slot on the same edge.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign full    = (cnt_q == (FIFO_DEPTH_BIT+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO drained back-to-back by a
// start/data/stop serialiser with a one-cycle tx_done per completed frame.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_DIV       = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_DEPTH_BIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  // wr_en is a valid strobe and full is its inverted ready: a byte is taken
  // on any edge with wr_en=1 and full=0; with full=1 it is silently dropped.
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic [FIFO_DEPTH_BIT:0] count,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  uart_state_t state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift_reg, shift_nx;
  logic             tx_reg, tx_nx;
  logic             bit_end;

  logic             fifo_rd;
  logic [7:0]       fifo_rd_data;
  logic             fifo_empty;

  uart_tx_fifo #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_DEPTH_BIT (FIFO_DEPTH_BIT)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_reg   <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      tx_reg   <= tx_nx;
    end
  end

  // Frame data needs no reset: it is always loaded by a pop before use.
  always_ff @(posedge clk) begin
    shift_reg <= shift_nx;
  end

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shift_nx    = shift_reg;
    tx_nx       = tx_reg;
    fifo_rd     = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_nx = 1'b1;
        if (!fifo_empty) begin
          fifo_rd     = 1'b1;
          shift_nx    = fifo_rd_data;
          tx_nx       = 1'b0;
          baud_cnt_nx = '0;
          state_nx    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          tx_nx       = shift_reg[0];
          bit_idx_nx  = '0;
          baud_cnt_nx = '0;
          state_nx    = ST_DATA;
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = ST_STOP;
          end else begin
            shift_nx   = {1'b0, shift_reg[7:1]};
            tx_nx      = shift_reg[1];
            bit_idx_nx = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_rd  = 1'b1;
            shift_nx = fifo_rd_data;
            tx_nx    = 1'b0;
            state_nx = ST_START;
          end else begin
            tx_nx    = 1'b1;
            state_nx = ST_IDLE;
          end
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end

      default: begin
        tx_nx    = 1'b1;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign busy    = (state != ST_IDLE);
  assign tx_done = (state == ST_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timer reference model checked every cycle,
// plus a line decoder feeding a byte scoreboard.
module tb_uart_tx_buffered;

  localparam int B     = 4;
  localparam int DEPTH = 8;
  localparam int DBIT  = 3;
  localparam int FRAME = 10 * B;

  // ---------------- clock / reset ----------------
  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic            wr_en   = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            full;
  logic [DBIT:0]   count;
  logic            tx;
  logic            busy;
  logic            tx_done;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .BAUD_DIV       (B),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_DEPTH_BIT (DBIT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of waiting bytes plus a countdown of the frame on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_cur   = 8'h00;
  int         m_left  = 0;
  int         m_pre;
  logic       m_pop;
  logic       m_push;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_left = 0;
    end else begin
      m_pre  = m_q.size();
      m_pop  = (m_pre > 0) && (m_left <= 1);
      m_push = wr_en && (m_pre < DEPTH);
      if (m_left > 0) m_left--;
      if (m_pop) begin
        m_cur  = m_q.pop_front();
        m_left = FRAME;
        exp_q.push_back(m_cur);
      end
      if (m_push) m_q.push_back(wr_data);
    end
  end

  function automatic logic model_tx();
    int b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / B;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  int done_cnt = 0;

  always @(negedge clk) begin
    check("tx_line", tx, model_tx());
    check("busy", busy, m_left > 0);
    check("tx_done", tx_done, m_left == 1);
    check("count", count, m_q.size());
    check("full", full, m_q.size() == DEPTH);
    if (tx_done) done_cnt++;
  end

  // ---------------- line decoder / scoreboard ----------------
  logic       prev_tx    = 1'b1;
  logic       dec_active = 1'b0;
  int         dec_pos    = 0;
  int         dec_total  = 0;
  logic [7:0] dec_byte   = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active) begin
        if (prev_tx && !tx) begin
          dec_active = 1'b1;
          dec_pos    = 0;
        end
      end else begin
        dec_pos++;
      end
      if (dec_active && (dec_pos % B) == B / 2) begin
        if (dec_pos / B == 0) begin
          check("start_bit", tx, 1'b0);
        end else if (dec_pos / B <= 8) begin
          dec_byte[dec_pos / B - 1] = tx;
        end else begin
          check("stop_bit", tx, 1'b1);
          check("sb_has_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("sb_byte", dec_byte, exp_q.pop_front());
          dec_total++;
          dec_active = 1'b0;
        end
      end
    end
    prev_tx = tx;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < 200);
    check("done_seen", tx_done, 1'b1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || count != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < max, 1'b1);
    idle(3);
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int gap;
  int dec_mark;
  int done_mark;

  initial begin
    idle(4);
    reset = 1'b0;

    // idle after reset
    idle(50);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 0);
    check("rst_full", full, 1'b0);
    check("rst_no_done", done_cnt, 0);

    // single byte: latency and frame length
    push(8'hA5);
    check("fall_not_early", tx, 1'b1);
    @(negedge clk);
    check("fall_latency", tx, 1'b0);
    cyc = 1;
    while (!tx_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, FRAME);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_once", done_cnt, 1);
    check("a5_decoded", dec_total, 1);

    // back-to-back frames
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_done(gap);
    wait_done(gap);
    check("gap_1_2", gap, FRAME);
    wait_done(gap);
    check("gap_2_3", gap, FRAME);
    wait_idle(200);
    check("b2b_decoded", dec_total, 4);

    // overflow: head in flight, eight queued, ninth dropped
    dec_mark = dec_total;
    push(8'h0F);
    for (int i = 0; i < 8; i++) begin
      push(8'(8'h10 + i));
      if (i == 6) check("not_full_at_7", full, 1'b0);
    end
    check("full_at_8", full, 1'b1);
    check("count_at_8", count, 8);
    push(8'h18);
    check("count_after_drop", count, 8);
    wait_done(gap);
    wr_en   = 1'b1;
    wr_data = 8'h99;
    @(negedge clk);
    wr_en   = 1'b0;
    check("pop_with_full_write", count, 7);
    wait_idle(1000);
    check("overflow_decoded", dec_total - dec_mark, 9);

    // reset during data bit 3 of 0x5A with two bytes queued
    push(8'h5A);
    push(8'h11);
    push(8'h22);
    idle(16);
    done_mark = done_cnt;
    #1 reset = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_count", count, 0);
    check("abort_busy", busy, 1'b0);
    idle(3);
    reset = 1'b0;
    idle(60);
    check("abort_no_done", done_cnt, done_mark);
    dec_mark = dec_total;
    push(8'h3C);
    wait_idle(200);
    check("after_abort_decoded", dec_total - dec_mark, 1);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
      else idle(1);
    end
    wait_idle(2000);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
